// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//   Control FSM and millisecond counter for the stopwatch datapath. Debounced
//   button pulses (start_stop, lap, clear) and a 1 kHz tick produce a running
//   millisecond count. The value shown on disp_count is either the live count
//   or the frozen lap value.
//
// Compile-time option:
//   STOPWATCH_SATURATE_EN  defined   : a counting tick at MAX holds count at
//                                      MAX, sets overflow and forces PAUSE;
//                                      start_stop stays locked out until
//                                      clear or reset.
//                          undefined : a counting tick at MAX wraps count to
//                                      0, sets sticky overflow and counting
//                                      continues in the same state.
//
// Parameters:
//   BITS  width of count / disp_count (>= 26 so that MAX fits)
//   MAX   last valid count (9:59:59.999 = 35999999 ms)
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   tick        in   single-cycle 1 kHz enable
//   start_stop  in   single-cycle start/stop pulse
//   lap         in   single-cycle lap pulse
//   clear       in   single-cycle clear pulse
//   count       out  live millisecond count
//   disp_count  out  lap_reg while in LAP, otherwise count
//   running     out  high in RUN and LAP
//   lap_active  out  high in LAP
//   overflow    out  sticky full-scale flag
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int BITS = 26,
    parameter int MAX  = 35999999
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            start_stop,
    input  logic            lap,
    input  logic            clear,
    output logic [BITS-1:0] count,
    output logic [BITS-1:0] disp_count,
    output logic            running,
    output logic            lap_active,
    output logic            overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [BITS-1:0] MAX_C  = BITS'(MAX);
    localparam logic [BITS-1:0] ZERO_C = {BITS{1'b0}};
    localparam logic [BITS-1:0] ONE_C  = {{(BITS-1){1'b0}}, 1'b1};

    state_t          state_r;
    logic [BITS-1:0] count_r;
    logic [BITS-1:0] lap_r;
    logic            overflow_r;
    logic            running_r;
    logic            lap_active_r;

    logic            counting_s;
    logic            full_s;
    logic [BITS-1:0] count_inc_s;
    state_t          trans_state_s;
    state_t          state_next_s;
    logic            lap_pre_s;
    logic            lap_load_s;
    logic            clear_s;
    logic            ss_block_s;

    // Counter increment: counting is judged against the current state, so a
    // transition taken on the same edge does not change whether this tick counts.
    always_comb begin
        counting_s  = tick && ((state_r == RUN) || (state_r == LAP));
        full_s      = counting_s && (count_r == MAX_C);
        count_inc_s = count_r;
        if (counting_s) begin
            if (count_r == MAX_C) begin
`ifdef STOPWATCH_SATURATE_EN
                count_inc_s = MAX_C;
`else
                count_inc_s = ZERO_C;
`endif
            end else begin
                count_inc_s = count_r + ONE_C;
            end
        end else begin
            count_inc_s = count_r;
        end
    end

    // Transition logic: per-state priority clear > start_stop > lap, where an
    // input ignored in a state falls through to the next one.
    always_comb begin
        trans_state_s = state_r;
        lap_pre_s     = 1'b0;
        clear_s       = 1'b0;
`ifdef STOPWATCH_SATURATE_EN
        ss_block_s    = overflow_r;
`else
        ss_block_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start_stop) begin
                    trans_state_s = RUN;
                end else begin
                    trans_state_s = IDLE;
                end
            end
            RUN: begin
                if (start_stop) begin
                    trans_state_s = PAUSE;
                end else if (lap) begin
                    trans_state_s = LAP;
                    lap_pre_s     = 1'b1;
                end else begin
                    trans_state_s = RUN;
                end
            end
            LAP: begin
                if (start_stop) begin
                    trans_state_s = PAUSE;
                end else if (lap) begin
                    trans_state_s = RUN;
                end else begin
                    trans_state_s = LAP;
                end
            end
            PAUSE: begin
                if (clear) begin
                    trans_state_s = IDLE;
                    clear_s       = 1'b1;
                end else if (start_stop && !ss_block_s) begin
                    trans_state_s = RUN;
                end else begin
                    trans_state_s = PAUSE;
                end
            end
            default: begin
                trans_state_s = IDLE;
            end
        endcase
    end

    // Full-scale override: in saturating builds a counting tick at MAX forces
    // PAUSE and wins over any coincident button.
    always_comb begin
`ifdef STOPWATCH_SATURATE_EN
        if (full_s) begin
            state_next_s = PAUSE;
            lap_load_s   = 1'b0;
        end else begin
            state_next_s = trans_state_s;
            lap_load_s   = lap_pre_s;
        end
`else
        state_next_s = trans_state_s;
        lap_load_s   = lap_pre_s;
`endif
    end

    // State, counter, lap latch and registered status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= ZERO_C;
            lap_r        <= ZERO_C;
            overflow_r   <= 1'b0;
            running_r    <= 1'b0;
            lap_active_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            running_r    <= (state_next_s == RUN) || (state_next_s == LAP);
            lap_active_r <= (state_next_s == LAP);
            if (clear_s) begin
                count_r    <= ZERO_C;
                lap_r      <= ZERO_C;
                overflow_r <= 1'b0;
            end else begin
                count_r <= count_inc_s;
                // lap latches the pre-increment count of this edge
                if (lap_load_s) begin
                    lap_r <= count_r;
                end else begin
                    lap_r <= lap_r;
                end
                if (full_s) begin
                    overflow_r <= 1'b1;
                end else begin
                    overflow_r <= overflow_r;
                end
            end
        end
    end

    assign count      = count_r;
    assign disp_count = (state_r == LAP) ? lap_r : count_r;
    assign running    = running_r;
    assign lap_active = lap_active_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//   Directed, table-driven bench for stopwatch_ctrl. MAX is reduced so the
//   full-scale corner is reachable in a short run. Honours
//   STOPWATCH_SATURATE_EN for the full-scale expectations.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    localparam int BITS  = 26;
    localparam int MAX_V = 1999;

    logic            clk;
    logic            reset;
    logic            tick;
    logic            start_stop;
    logic            lap;
    logic            clear;
    logic [BITS-1:0] count;
    logic [BITS-1:0] disp_count;
    logic            running;
    logic            lap_active;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.BITS(BITS), .MAX(MAX_V)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .count      (count),
        .disp_count (disp_count),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic  r;
        logic  ss;
        logic  lp;
        logic  cl;
        logic  tk;
        int    ec;
        int    ed;
        logic  er;
        logic  el;
        logic  eo;
        string nm;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int ec, input int ed,
                           input logic er, input logic el, input logic eo);
        chk({nm, ".count"},      int'(count),      ec);
        chk({nm, ".disp_count"}, int'(disp_count), ed);
        chk({nm, ".running"},    int'(running),    int'(er));
        chk({nm, ".lap_active"}, int'(lap_active), int'(el));
        chk({nm, ".overflow"},   int'(overflow),   int'(eo));
    endtask

    // Apply one cycle of inputs, then return 1 ns after the rising edge.
    task automatic drive(input logic r, input logic ss, input logic lp,
                         input logic cl, input logic tk);
        @(negedge clk);
        reset = r; start_stop = ss; lap = lp; clear = cl; tick = tk;
        @(posedge clk);
        #1;
        reset = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0; tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;

        //            r     ss    lp    cl    tk    cnt disp run   lapa  ovf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "reset"};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, "idle_tick"};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0, "idle_ss_tick"};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1'b1, 1'b0, 1'b0, "run_tick1"};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 1'b1, 1'b0, 1'b0, "run_tick2"};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3, 3, 1'b1, 1'b0, 1'b0, "run_clear"};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4, 3, 1'b1, 1'b1, 1'b0, "run_lap_tick"};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 3, 1'b1, 1'b1, 1'b0, "lap_tick"};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5, 3, 1'b1, 1'b1, 1'b0, "lap_clear"};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 6, 6, 1'b0, 1'b0, 1'b0, "lap_ss_tick"};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6, 6, 1'b0, 1'b0, 1'b0, "pause_tick"};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6, 6, 1'b0, 1'b0, 1'b0, "pause_lap"};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6, 6, 1'b1, 1'b0, 1'b0, "pause_ss"};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7, 7, 1'b0, 1'b0, 1'b0, "run_ss_tick"};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, "pause_clear_ss"};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, "idle_lap"};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, "idle_ss"};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, "reset_wins"};

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].r, vecs[i].ss, vecs[i].lp, vecs[i].cl, vecs[i].tk);
            chk_all(vecs[i].nm, vecs[i].ec, vecs[i].ed, vecs[i].er, vecs[i].el, vecs[i].eo);
        end

        // Long run, then reset mid-count
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1500);
        chk_all("run1500", 1500, 1500, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_all("reset_mid", 0, 0, 1'b0, 1'b0, 1'b0);

        // Lap latch with coincident tick, freeze, release
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(400);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_all("lap400", 401, 400, 1'b1, 1'b1, 1'b0);
        ticks(10);
        chk_all("lap_frozen", 411, 400, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_all("lap_release", 411, 411, 1'b1, 1'b0, 1'b0);

        // Pause holds, clear returns to idle, clear in RUN ignored
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(1000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("pause1000", 1000, 1000, 1'b0, 1'b0, 1'b0);
        ticks(50);
        chk_all("pause_hold", 1000, 1000, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("pause_clear", 0, 0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("run_clear_ign", 5, 5, 1'b1, 1'b0, 1'b0);

        // Full scale: reach MAX-1, then two ticks
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        ticks(MAX_V - 1);
        chk_all("at_max_m1", MAX_V - 1, MAX_V - 1, 1'b1, 1'b0, 1'b0);
        ticks(1);
        chk_all("at_max", MAX_V, MAX_V, 1'b1, 1'b0, 1'b0);
        ticks(1);
`ifdef STOPWATCH_SATURATE_EN
        chk_all("sat_hold", MAX_V, MAX_V, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("sat_ss_ign", MAX_V, MAX_V, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("sat_clear", 0, 0, 1'b0, 1'b0, 1'b0);
`else
        chk_all("wrap", 0, 0, 1'b1, 1'b0, 1'b1);
        ticks(1);
        chk_all("wrap_cont", 1, 1, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_all("wrap_pause", 1, 1, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_all("wrap_clear", 0, 0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
